// File: rtl/stopwatch_pkg.sv
// Shared digit widths, digit limits and the time-set record for the stopwatch datapath.
package stopwatch_pkg;

  localparam int unsigned MSEC_W = 7;
  localparam int unsigned SEC_W  = 6;
  localparam int unsigned MIN_W  = 6;
  localparam int unsigned HOUR_W = 5;

  localparam logic [MSEC_W-1:0] MSEC_MAX = 7'd99;
  localparam logic [SEC_W-1:0]  SEC_MAX  = 6'd59;
  localparam logic [MIN_W-1:0]  MIN_MAX  = 6'd59;
  localparam logic [HOUR_W-1:0] HOUR_MAX = 5'd23;

  typedef enum logic {
    ModeWatch = 1'b0,
    ModeCount = 1'b1
  } disp_mode_e;

  typedef struct packed {
    logic [HOUR_W-1:0] hour;
    logic [MIN_W-1:0]  min;
    logic [SEC_W-1:0]  sec;
    logic [MSEC_W-1:0] msec;
  } time_t;

endpackage

// File: rtl/time_counter_set.sv
// One hour:min:sec:centisecond time set: a clock divider feeding a 4-digit up/down cascade.
module time_counter_set
  import stopwatch_pkg::*;
#(
  parameter bit          DIR_EN    = 1'b0,
  parameter int unsigned INIT_HOUR = 0,
  parameter int unsigned DIV       = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic              clear,
  input  logic              dir,
  output logic [MSEC_W-1:0] msec,
  output logic [SEC_W-1:0]  sec,
  output logic [MIN_W-1:0]  min,
  output logic [HOUR_W-1:0] hour,
  output logic              tick
);

  localparam int unsigned DivW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(DIV - 1);

  logic [DivW-1:0]   div_q, div_d;
  logic [MSEC_W-1:0] msec_q, msec_d;
  logic [SEC_W-1:0]  sec_q, sec_d;
  logic [MIN_W-1:0]  min_q, min_d;
  logic [HOUR_W-1:0] hour_q, hour_d;
  logic              down;

  assign down = DIR_EN && dir;

  always_comb begin
    tick   = run && !clear && (div_q == DivLast);
    div_d  = div_q;
    msec_d = msec_q;
    sec_d  = sec_q;
    min_d  = min_q;
    hour_d = hour_q;
    if (clear) begin
      div_d  = '0;
      msec_d = '0;
      sec_d  = '0;
      min_d  = '0;
      hour_d = '0;
    end else begin
      // Divider holds while paused so a resume continues mid-period.
      if (run) div_d = tick ? '0 : div_q + 1'b1;
      if (tick && down) begin
        if (msec_q == '0) begin
          msec_d = MSEC_MAX;
          if (sec_q == '0) begin
            sec_d = SEC_MAX;
            if (min_q == '0) begin
              min_d  = MIN_MAX;
              hour_d = (hour_q == '0) ? HOUR_MAX : hour_q - 1'b1;
            end else begin
              min_d = min_q - 1'b1;
            end
          end else begin
            sec_d = sec_q - 1'b1;
          end
        end else begin
          msec_d = msec_q - 1'b1;
        end
      end else if (tick) begin
        if (msec_q == MSEC_MAX) begin
          msec_d = '0;
          if (sec_q == SEC_MAX) begin
            sec_d = '0;
            if (min_q == MIN_MAX) begin
              min_d  = '0;
              hour_d = (hour_q == HOUR_MAX) ? '0 : hour_q + 1'b1;
            end else begin
              min_d = min_q + 1'b1;
            end
          end else begin
            sec_d = sec_q + 1'b1;
          end
        end else begin
          msec_d = msec_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q  <= '0;
      msec_q <= '0;
      sec_q  <= '0;
      min_q  <= '0;
      hour_q <= HOUR_W'(INIT_HOUR);
    end else begin
      div_q  <= div_d;
      msec_q <= msec_d;
      sec_q  <= sec_d;
      min_q  <= min_d;
      hour_q <= hour_d;
    end
  end

  assign msec = msec_q;
  assign sec  = sec_q;
  assign min  = min_q;
  assign hour = hour_q;

endmodule

// File: rtl/stopwatch_datapath.sv
// Stopwatch datapath top: free-running WATCH set, controllable COUNT set, registered display mux.
module stopwatch_datapath
  import stopwatch_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 100_000_000,
  parameter int unsigned TICK_HZ    = 100,
  parameter int unsigned WATCH_HOUR = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              clear,
  input  logic              up_down,
  input  logic              mode,
  output logic [MSEC_W-1:0] msec,
  output logic [SEC_W-1:0]  sec,
  output logic [MIN_W-1:0]  min,
  output logic [HOUR_W-1:0] hour,
  output logic              tick
);

  localparam int unsigned Div = CLK_FREQ / TICK_HZ;

  time_t watch_t, count_t, disp_d, disp_q;
  logic  count_tick, watch_tick_unused;
  logic  tick_q;

  time_counter_set #(
    .DIR_EN   (1'b0),
    .INIT_HOUR(WATCH_HOUR),
    .DIV      (Div)
  ) u_watch (
    .clk  (clk),
    .reset(reset),
    .run  (1'b1),
    .clear(1'b0),
    .dir  (1'b0),
    .msec (watch_t.msec),
    .sec  (watch_t.sec),
    .min  (watch_t.min),
    .hour (watch_t.hour),
    .tick (watch_tick_unused)
  );

  time_counter_set #(
    .DIR_EN   (1'b1),
    .INIT_HOUR(0),
    .DIV      (Div)
  ) u_count (
    .clk  (clk),
    .reset(reset),
    .run  (en),
    .clear(clear),
    .dir  (up_down),
    .msec (count_t.msec),
    .sec  (count_t.sec),
    .min  (count_t.min),
    .hour (count_t.hour),
    .tick (count_tick)
  );

  always_comb begin
    disp_d = (disp_mode_e'(mode) == ModeCount) ? count_t : watch_t;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      disp_q <= '0;
      tick_q <= 1'b0;
    end else begin
      disp_q <= disp_d;
      tick_q <= count_tick;
    end
  end

  assign msec = disp_q.msec;
  assign sec  = disp_q.sec;
  assign min  = disp_q.min;
  assign hour = disp_q.hour;
  assign tick = tick_q;

endmodule

// File: tb/tb_stopwatch_datapath.sv
// Directed bench for stopwatch_datapath at divide-by-10 (CLK_FREQ=100, TICK_HZ=10).
module tb_stopwatch_datapath;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       en = 1'b0;
  logic       clear = 1'b0;
  logic       up_down = 1'b0;
  logic       mode = 1'b0;
  logic [6:0] msec;
  logic [5:0] sec;
  logic [5:0] min;
  logic [4:0] hour;
  logic       tick;

  int total = 0;
  int bad = 0;
  int edges = 0;

  stopwatch_datapath #(
    .CLK_FREQ  (100),
    .TICK_HZ   (10),
    .WATCH_HOUR(12)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .en     (en),
    .clear  (clear),
    .up_down(up_down),
    .mode   (mode),
    .msec   (msec),
    .sec    (sec),
    .min    (min),
    .hour   (hour),
    .tick   (tick)
  );

  always #5 clk = ~clk;

  // Clock edges since reset release; drives the WATCH reference model.
  always @(posedge clk) if (reset) edges <= edges + 1;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $display("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic chk_time(input string tag, input int h, input int m, input int s, input int cs);
    chk({tag, ".hour"}, 32'(hour), h);
    chk({tag, ".min"}, 32'(min), m);
    chk({tag, ".sec"}, 32'(sec), s);
    chk({tag, ".msec"}, 32'(msec), cs);
  endtask

  // Display after edge e shows WATCH after edge e-1: (e-1)/10 centiseconds past 12:00.
  task automatic chk_watch(input string tag);
    int t;
    t = (edges - 1) / 10;
    chk_time(tag, (12 + t / 360000) % 24, (t / 6000) % 60, (t / 100) % 60, t % 100);
  endtask

  initial begin
    int ticks;
    int terr;

    // Reset state
    step(2);
    chk_time("rst", 0, 0, 0, 0);
    chk("rst.tick", 32'(tick), 0);

    // 1: WATCH idles then advances
    reset = 1'b1;
    step(10);
    chk_time("t1_idle", 12, 0, 0, 0);
    step(100);
    chk_time("t1_run", 12, 0, 0, 10);
    chk_watch("t1_model");

    // 2: COUNT up 1000 ticks, tick every 10 cycles
    mode = 1'b1;
    en = 1'b1;
    ticks = 0;
    terr = 0;
    for (int k = 1; k <= 10001; k++) begin
      step(1);
      if (tick === 1'b1) ticks++;
      if (tick !== ((k % 10) == 0)) terr++;
    end
    chk("t2_tick_count", 32'(ticks), 1000);
    chk("t2_tick_period", 32'(terr), 0);
    chk_time("t2_count", 0, 0, 10, 0);

    // 3: run to 00:00:59:99, then carry into minutes
    step(49990);
    chk_time("t3_pre", 0, 0, 59, 99);
    step(10);
    chk_time("t3_carry", 0, 1, 0, 0);

    // 5: clear at terminal count beats en and suppresses the tick
    step(8);
    chk_time("t5_hold", 0, 1, 0, 0);
    clear = 1'b1;
    step(1);
    chk("t5_no_tick", 32'(tick), 0);
    step(1);
    chk_time("t5_clr", 0, 0, 0, 0);
    chk("t5_no_tick2", 32'(tick), 0);

    // 4: release clear counting down; first tick 10 cycles later wraps to 23:59:59:99
    clear = 1'b0;
    up_down = 1'b1;
    step(9);
    chk("t5_tick_early", 32'(tick), 0);
    step(1);
    chk("t5_tick_first", 32'(tick), 1);
    step(1);
    chk_time("t4_wrap_down", 23, 59, 59, 99);

    // Direction change mid-period leaves the value alone; up ripples back to zero
    up_down = 1'b0;
    step(1);
    chk_time("t4_no_glitch", 23, 59, 59, 99);
    step(9);
    chk_time("t3_wrap_up", 0, 0, 0, 0);
    step(10);
    chk_time("t4_up_one", 0, 0, 0, 1);
    up_down = 1'b1;
    step(10);
    chk_time("t4_down_zero", 0, 0, 0, 0);

    // 6: pause 37 cycles mid-period
    en = 1'b0;
    ticks = 0;
    for (int k = 0; k < 37; k++) begin
      step(1);
      if (tick === 1'b1) ticks++;
    end
    chk("t6_pause_ticks", 32'(ticks), 0);
    chk_time("t6_hold", 0, 0, 0, 0);
    mode = 1'b0;
    step(1);
    chk_watch("t6_watch");

    // Resume continues the paused period: tick after 9 cycles, not 10
    mode = 1'b1;
    en = 1'b1;
    step(8);
    chk("t6_resume_early", 32'(tick), 0);
    step(1);
    chk("t6_resume_tick", 32'(tick), 1);
    step(1);
    chk_time("t6_resume_val", 23, 59, 59, 99);

    // Asynchronous reset mid-run, checked before the next clock edge
    #2;
    reset = 1'b0;
    #1;
    chk_time("t6_async_rst", 0, 0, 0, 0);
    chk("t6_async_tick", 32'(tick), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
